sseg_arbiter: RTL and testbench

SSEG_ARBITER -- requirements
Module: sseg_arbiter

---
 rtl/sseg_arbiter.sv | 149 ++++++++++++++
 tb/tb_sseg_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sseg_arbiter.sv
// Round-robin arbiter that hands a 4-digit hex display to one of four requesters for DWELL cycles.
// Optional macro SSEG_ARB_LIVE_EN: when defined, the display follows the owner's value live during SHOW.
module sseg_arbiter #(
  parameter int DWELL = 1000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  req,
  input  logic [15:0] val0,
  input  logic [15:0] val1,
  input  logic [15:0] val2,
  input  logic [15:0] val3,
  output logic [3:0]  grant,
  output logic [3:0]  regA,
  output logic [3:0]  regB,
  output logic [3:0]  regC,
  output logic [3:0]  regD,
  output logic        blank,
  output logic        done,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHOW    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  // Handshake: req[i] is a level; the owner keeps the display while req[i] stays
  // high, up to DWELL cycles. grant is one-hot while owned, done pulses once at the end.

  state_t        state_q, state_n;
  logic [3:0]    grant_q, grant_n;
  logic          blank_q, blank_n;
  logic          done_q, done_n;
  logic [15:0]   snap_q, snap_n;
  logic [1:0]    ptr_q, ptr_n;
  logic [1:0]    win_q, win_n;
  logic [CW-1:0] cnt_q, cnt_n;

  logic [15:0]   vals [4];
  logic [1:0]    pick;
  logic [1:0]    idx;
  logic          found;

  assign vals[0] = val0;
  assign vals[1] = val1;
  assign vals[2] = val2;
  assign vals[3] = val3;

  // Search from ptr upward; the 2-bit add provides the 3->0 wrap.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state_q;
    grant_n = grant_q;
    blank_n = blank_q;
    done_n  = 1'b0;
    snap_n  = snap_q;
    ptr_n   = ptr_q;
    win_n   = win_q;
    cnt_n   = cnt_q;
    unique case (state_q)
      IDLE: begin
        grant_n = '0;
        blank_n = 1'b1;
        if (found) begin
          win_n   = pick;
          grant_n = 4'b0001 << pick;
          snap_n  = vals[pick];
          blank_n = 1'b0;
          cnt_n   = '0;
          state_n = SHOW;
        end
      end
      SHOW: begin
`ifdef SSEG_ARB_LIVE_EN
        snap_n = vals[win_q];
`endif
        // Expiry and early release collapse into the same single exit.
        if (!req[win_q] || (cnt_q == LAST)) begin
          grant_n = '0;
          blank_n = 1'b1;
          done_n  = 1'b1;
          state_n = RELEASE;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        grant_n = '0;
        blank_n = 1'b1;
        ptr_n   = win_q + 2'd1;
        state_n = IDLE;
      end
      default: begin
        grant_n = '0;
        blank_n = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      grant_q <= '0;
      blank_q <= 1'b1;
      done_q  <= 1'b0;
      snap_q  <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      grant_q <= grant_n;
      blank_q <= blank_n;
      done_q  <= done_n;
      snap_q  <= snap_n;
      ptr_q   <= ptr_n;
      win_q   <= win_n;
      cnt_q   <= cnt_n;
    end
  end

  assign grant     = grant_q;
  assign blank     = blank_q;
  assign done      = done_q;
  assign regA      = snap_q[15:12];
  assign regB      = snap_q[11:8];
  assign regC      = snap_q[7:4];
  assign regD      = snap_q[3:0];
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sseg_arbiter.sv
// Directed bench for sseg_arbiter with DWELL=4, plus a DWELL=1 instance for the single-cycle SHOW case.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_sseg_arbiter;

  logic        clk;
  logic        clr;
  logic [3:0]  req;
  logic [15:0] val0, val1, val2, val3;
  logic [3:0]  grant, grant1;
  logic [3:0]  rega, regb, regc, regd;
  logic [3:0]  rega1, regb1, regc1, regd1;
  logic        blank, blank1, done, done1;
  logic [1:0]  state_dbg, state_dbg1;

  int vectors;
  int miscompares;

  sseg_arbiter #(.DWELL(4)) u_dut (
    .clk(clk), .clr(clr), .req(req),
    .val0(val0), .val1(val1), .val2(val2), .val3(val3),
    .grant(grant), .regA(rega), .regB(regb), .regC(regc), .regD(regd),
    .blank(blank), .done(done), .state_dbg(state_dbg)
  );

  sseg_arbiter #(.DWELL(1)) u_dut1 (
    .clk(clk), .clr(clr), .req(req),
    .val0(val0), .val1(val1), .val2(val2), .val3(val3),
    .grant(grant1), .regA(rega1), .regB(regb1), .regC(regc1), .regD(regd1),
    .blank(blank1), .done(done1), .state_dbg(state_dbg1)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic [3:0] eg, input logic eb,
                           input logic ed, input logic [15:0] eregs);
    check({tag, ".grant"}, {28'd0, grant}, {28'd0, eg});
    check({tag, ".blank"}, {31'd0, blank}, {31'd0, eb});
    check({tag, ".done"},  {31'd0, done},  {31'd0, ed});
    check({tag, ".regs"},  {16'd0, rega, regb, regc, regd}, {16'd0, eregs});
  endtask

  task automatic do_reset();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // driver / scenarios
  initial begin
    logic [15:0] rot_vals [4];
    int rot_seq [5];
    vectors     = 0;
    miscompares = 0;
    clr  = 1'b1;
    req  = 4'b1111;
    val0 = 16'h1A2F;
    val1 = 16'h4567;
    val2 = 16'h89AB;
    val3 = 16'hCDEF;
    @(negedge clk);

    // reset held two cycles with every requester active
    tick();
    tick();
    check_out("reset", 4'b0000, 1'b1, 1'b0, 16'h0000);
    check("reset.state", {30'd0, state_dbg}, 32'd0);

    // single grant, DWELL=4 and DWELL=1 side by side
    clr = 1'b0;
    req = 4'b0001;
    tick();
    check_out("single.c1", 4'b0001, 1'b0, 1'b0, 16'h1A2F);
    check("single.state", {30'd0, state_dbg}, 32'd1);
    check("dwell1.c1.grant", {28'd0, grant1}, 32'h1);
    tick();
    check_out("single.c2", 4'b0001, 1'b0, 1'b0, 16'h1A2F);
    check("dwell1.rel.grant", {28'd0, grant1}, 32'h0);
    check("dwell1.rel.done", {31'd0, done1}, 32'h1);
    tick();
    check_out("single.c3", 4'b0001, 1'b0, 1'b0, 16'h1A2F);
    check("dwell1.idle.done", {31'd0, done1}, 32'h0);
    tick();
    check_out("single.c4", 4'b0001, 1'b0, 1'b0, 16'h1A2F);
    tick();
    check_out("single.rel", 4'b0000, 1'b1, 1'b1, 16'h1A2F);
    req = 4'b0000;
    tick();
    check_out("single.idle", 4'b0000, 1'b1, 1'b0, 16'h1A2F);
    tick();
    check_out("single.hold", 4'b0000, 1'b1, 1'b0, 16'h1A2F);

    // rotation with all four requesting
    do_reset();
    val0 = 16'h0123;
    rot_vals[0] = 16'h0123;
    rot_vals[1] = 16'h4567;
    rot_vals[2] = 16'h89AB;
    rot_vals[3] = 16'hCDEF;
    rot_seq[0] = 0; rot_seq[1] = 1; rot_seq[2] = 2; rot_seq[3] = 3; rot_seq[4] = 0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_out($sformatf("rot%0d.c1", k), 4'(1 << rot_seq[k]), 1'b0, 1'b0, rot_vals[rot_seq[k]]);
      for (int c = 2; c <= 4; c++) begin
        tick();
        check($sformatf("rot%0d.c%0d.grant", k, c), {28'd0, grant}, 32'(1 << rot_seq[k]));
      end
      tick();
      check_out($sformatf("rot%0d.rel", k), 4'b0000, 1'b1, 1'b1, rot_vals[rot_seq[k]]);
      tick();
      check_out($sformatf("rot%0d.gap", k), 4'b0000, 1'b1, 1'b0, rot_vals[rot_seq[k]]);
    end

    // early release after two SHOW cycles, then search resumes at requester 3
    do_reset();
    req = 4'b0100;
    tick();
    check_out("early.c1", 4'b0100, 1'b0, 1'b0, 16'h89AB);
    tick();
    check_out("early.c2", 4'b0100, 1'b0, 1'b0, 16'h89AB);
    req = 4'b0000;
    tick();
    check_out("early.rel", 4'b0000, 1'b1, 1'b1, 16'h89AB);
    req = 4'b1001;
    tick();
    check_out("early.idle", 4'b0000, 1'b1, 1'b0, 16'h89AB);
    tick();
    check_out("early.next", 4'b1000, 1'b0, 1'b0, 16'hCDEF);
    req = 4'b0000;
    tick();
    tick();

    // reset in SHOW cycle 3
    req = 4'b1000;
    tick();
    check_out("midrst.c1", 4'b1000, 1'b0, 1'b0, 16'hCDEF);
    tick();
    tick();
    clr = 1'b1;
    req = 4'b1010;
    tick();
    check_out("midrst.rst", 4'b0000, 1'b1, 1'b0, 16'h0000);
    check("midrst.state", {30'd0, state_dbg}, 32'd0);
    clr = 1'b0;
    tick();
    check_out("midrst.next", 4'b0010, 1'b0, 1'b0, 16'h4567);

    // live versus snapshot display
    do_reset();
    val0 = 16'h1111;
    req  = 4'b0001;
    tick();
    check_out("live.c1", 4'b0001, 1'b0, 1'b0, 16'h1111);
    val0 = 16'h2222;
    tick();
`ifdef SSEG_ARB_LIVE_EN
    check_out("live.c2", 4'b0001, 1'b0, 1'b0, 16'h2222);
`else
    check_out("live.c2", 4'b0001, 1'b0, 1'b0, 16'h1111);
`endif

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
